// File: rtl/bin16_to_ascii_dec.sv
// Registered 16-bit unsigned binary to 7-character ASCII decimal field converter.
// Optional macro BLANK_LEADING_ZEROS_EN replaces leading zero digits (char1..char4) with PAD_CHAR.
module bin16_to_ascii_dec #(
   parameter logic [6:0] PAD_CHAR   = 7'h20,
   parameter logic [6:0] DIGIT_BASE = 7'h30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] input_val,
   output logic [48:0] packed_val,
   output logic        out_valid
);

   logic [19:0] bcd;
   logic [3:0]  digit [5];
   logic [6:0]  chars [7];
   logic [48:0] field;
   logic [48:0] packed_val_d, packed_val_q;
   logic        out_valid_d, out_valid_q;

   // Shift-add-3 over all 16 input bits; the top 20 bits end up holding five BCD digits.
   always_comb begin
      logic [35:0] work;
      work = {20'd0, input_val};
      for (int i = 0; i < 16; i++) begin
         for (int d = 0; d < 5; d++) begin
            if (work[16 + 4*d +: 4] >= 4'd5) begin
               work[16 + 4*d +: 4] = work[16 + 4*d +: 4] + 4'd3;
            end
         end
         work = {work[34:0], 1'b0};
      end
      bcd = work[35:16];
   end

   // digit[0] is ten-thousands, digit[4] is units.
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         digit[k] = bcd[4*(4-k) +: 4];
      end
   end

   always_comb begin
`ifdef BLANK_LEADING_ZEROS_EN
      logic leading;
      leading = 1'b1;
`endif
      for (int c = 0; c < 7; c++) begin
         chars[c] = PAD_CHAR;
      end
      for (int k = 0; k < 4; k++) begin
`ifdef BLANK_LEADING_ZEROS_EN
         if (leading && (digit[k] == 4'd0)) begin
            chars[k+1] = PAD_CHAR;
         end else begin
            leading    = 1'b0;
            chars[k+1] = DIGIT_BASE + {3'd0, digit[k]};
         end
`else
         chars[k+1] = DIGIT_BASE + {3'd0, digit[k]};
`endif
      end
      // Units cell always shows a digit so zero renders as '0'.
      chars[5] = DIGIT_BASE + {3'd0, digit[4]};
      field = {chars[0], chars[1], chars[2], chars[3], chars[4], chars[5], chars[6]};
   end

   always_comb begin
      packed_val_d = packed_val_q;
      out_valid_d  = 1'b0;
      if (in_valid) begin
         packed_val_d = field;
         out_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         packed_val_q <= {7{PAD_CHAR}};
         out_valid_q  <= 1'b0;
      end else begin
         packed_val_q <= packed_val_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign packed_val = packed_val_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_bin16_to_ascii_dec.sv
// Self-checking bench for bin16_to_ascii_dec: fixed vector table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_bin16_to_ascii_dec;

   localparam logic [6:0] P = 7'h20;

   typedef struct {
      logic [15:0] val;
      logic [48:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] input_val = 16'd0;
   logic [48:0] packed_val;
   logic        out_valid;

   int compared = 0;
   int mismatched = 0;

   vec_t vecs [8];

   bin16_to_ascii_dec dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .input_val  (input_val),
      .packed_val (packed_val),
      .out_valid  (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [48:0] packChars(input logic [6:0] c0, c1, c2, c3, c4, c5, c6);
      return {c0, c1, c2, c3, c4, c5, c6};
   endfunction

   // Reference: decimal digits by division, then layout and optional blanking.
   function automatic logic [48:0] refField(input int v);
      logic [6:0] c [7];
      int         d [5];
      int         div;
      bit         leading;
      div = 10000;
      for (int i = 0; i < 5; i++) begin
         d[i] = (v / div) % 10;
         div  = div / 10;
      end
      c[0] = P;
      c[6] = P;
      leading = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (d[i] != 0 || i == 4) leading = 1'b0;
         c[i+1] = 7'(8'h30 + d[i]);
`ifdef BLANK_LEADING_ZEROS_EN
         if (leading) c[i+1] = P;
`endif
      end
      return {c[0], c[1], c[2], c[3], c[4], c[5], c[6]};
   endfunction

   // Drive one cycle's inputs at the falling edge, then settle just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic vld, input logic [15:0] val);
      @(negedge clk);
      reset     = rst;
      in_valid  = vld;
      input_val = val;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [48:0] expPacked, input logic expValid);
      compared++;
      if (packed_val !== expPacked) begin
         mismatched++;
         $display("[TB] FAIL %s packed_val: got %h want %h", name, packed_val, expPacked);
      end
      compared++;
      if (out_valid !== expValid) begin
         mismatched++;
         $display("[TB] FAIL %s out_valid: got %b want %b", name, out_valid, expValid);
      end
   endtask

   initial begin
      logic [48:0] expPacked;
      logic        vld;
      logic [15:0] val;

      vecs[0] = '{16'd12345, packChars(P, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, P)};
`ifdef BLANK_LEADING_ZEROS_EN
      vecs[1] = '{16'd0,     packChars(P, P, P, P, P, 7'h30, P)};
`else
      vecs[1] = '{16'd0,     packChars(P, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30, P)};
`endif
      vecs[2] = '{16'd65535, packChars(P, 7'h36, 7'h35, 7'h35, 7'h33, 7'h35, P)};
`ifdef BLANK_LEADING_ZEROS_EN
      vecs[3] = '{16'd120,   packChars(P, P, P, 7'h31, 7'h32, 7'h30, P)};
`else
      vecs[3] = '{16'd120,   packChars(P, 7'h30, 7'h30, 7'h31, 7'h32, 7'h30, P)};
`endif
      vecs[4] = '{16'd10000, packChars(P, 7'h31, 7'h30, 7'h30, 7'h30, 7'h30, P)};
`ifdef BLANK_LEADING_ZEROS_EN
      vecs[5] = '{16'd1005,  packChars(P, P, 7'h31, 7'h30, 7'h30, 7'h35, P)};
      vecs[6] = '{16'd7,     packChars(P, P, P, P, P, 7'h37, P)};
      vecs[7] = '{16'd9999,  packChars(P, P, 7'h39, 7'h39, 7'h39, 7'h39, P)};
`else
      vecs[5] = '{16'd1005,  packChars(P, 7'h30, 7'h31, 7'h30, 7'h30, 7'h35, P)};
      vecs[6] = '{16'd7,     packChars(P, 7'h30, 7'h30, 7'h30, 7'h30, 7'h37, P)};
      vecs[7] = '{16'd9999,  packChars(P, 7'h30, 7'h39, 7'h39, 7'h39, 7'h39, P)};
`endif

      applyStimulus(1'b1, 1'b0, 16'd0);
      applyStimulus(1'b1, 1'b0, 16'd0);
      applyStimulus(1'b0, 1'b0, 16'd0);
      checkOutput("reset_state", {7{P}}, 1'b0);

      // Back-to-back table application; out_valid must stay high throughout.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, vecs[i].val);
         checkOutput($sformatf("vec%0d_%0d", i, vecs[i].val), vecs[i].exp, 1'b1);
      end

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 16'(i * 1111));
         checkOutput($sformatf("hold%0d", i), vecs[7].exp, 1'b0);
      end

      applyStimulus(1'b0, 1'b1, 16'd12345);
      checkOutput("pre_reset_load", vecs[0].exp, 1'b1);
      applyStimulus(1'b1, 1'b1, 16'd4321);
      checkOutput("reset_priority", {7{P}}, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'd4321);
      checkOutput("after_reset_idle", {7{P}}, 1'b0);

      expPacked = {7{P}};
      for (int i = 0; i < 300; i++) begin
         vld = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 5))
            0:       val = 16'($urandom_range(0, 9));
            1:       val = 16'($urandom_range(0, 999));
            2:       val = 16'hFFFF - 16'($urandom_range(0, 20));
            default: val = 16'($urandom);
         endcase
         applyStimulus(1'b0, vld, val);
         if (vld) expPacked = refField(int'(val));
         checkOutput($sformatf("rand%0d_%0d_%0b", i, val, vld), expPacked, vld);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
